// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Ports: i_clk/i_arst, i_start/i_op/i_data_a/i_data_b request, i_kill flush,
//        o_busy/o_done/o_div_zero status, o_hi/o_lo results.
module mdu_iter #(
    parameter  int DATA_WIDTH = 32,
    parameter  int STEP       = 1,
    localparam int ITER       = DATA_WIDTH / STEP
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic                  i_start,
    input  logic [2:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_data_a,
    input  logic [DATA_WIDTH-1:0] i_data_b,
    input  logic                  i_kill,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_hi,
    output logic [DATA_WIDTH-1:0] o_lo,
    output logic                  o_div_zero
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   hi_acc_q, hi_acc_d;
    logic [W-1:0]   lo_acc_q, lo_acc_d;
    logic [W-1:0]   opnd_q, opnd_d;
    logic           is_div_q, is_div_d;
    logic           neg_lo_q, neg_lo_d;
    logic           neg_hi_q, neg_hi_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;
    logic           done_q, done_d;
    logic           div_zero_q, div_zero_d;

    // One cycle worth of iteration
    logic [W-1:0]   hi_n, lo_n;
    logic [W:0]     shf, dif, sum;

    // Operand magnitudes and signs at request time
    logic           sgn_op;
    logic           sa, sb;
    logic [W-1:0]   mag_a, mag_b;

    // Sign-corrected results computed during FIX
    logic [2*W-1:0] prod, prod_fix;
    logic [W-1:0]   fix_hi, fix_lo;

    always_comb begin
        sgn_op = ~i_op[0];
        sa     = sgn_op & i_data_a[W-1];
        sb     = sgn_op & i_data_b[W-1];
        mag_a  = sa ? ('0 - i_data_a) : i_data_a;
        mag_b  = sb ? ('0 - i_data_b) : i_data_b;
    end

    // Multiply: {hi,lo} holds partial product over the shifting multiplier.
    // Divide: hi is the partial remainder, lo shifts dividend out and
    // quotient bits in (restoring division).
    always_comb begin
        hi_n = hi_acc_q;
        lo_n = lo_acc_q;
        shf  = '0;
        dif  = '0;
        sum  = '0;
        for (int s = 0; s < STEP; s++) begin
            if (is_div_q) begin
                shf = {hi_n, lo_n[W-1]};
                dif = shf - {1'b0, opnd_q};
                // No borrow means the divisor fits into the shifted remainder
                if (!dif[W]) begin
                    hi_n = dif[W-1:0];
                    lo_n = {lo_n[W-2:0], 1'b1};
                end else begin
                    hi_n = shf[W-1:0];
                    lo_n = {lo_n[W-2:0], 1'b0};
                end
            end else begin
                sum  = {1'b0, hi_n} + (lo_n[0] ? {1'b0, opnd_q} : '0);
                {hi_n, lo_n} = {sum, lo_n[W-1:1]};
            end
        end
    end

    always_comb begin
        prod     = {hi_acc_q, lo_acc_q};
        prod_fix = neg_lo_q ? ('0 - prod) : prod;
        if (is_div_q) begin
            fix_lo = neg_lo_q ? ('0 - lo_acc_q) : lo_acc_q;
            fix_hi = neg_hi_q ? ('0 - hi_acc_q) : hi_acc_q;
        end else begin
            fix_lo = prod_fix[W-1:0];
            fix_hi = prod_fix[2*W-1:W];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_acc_d   = hi_acc_q;
        lo_acc_d   = lo_acc_q;
        opnd_d     = opnd_q;
        is_div_d   = is_div_q;
        neg_lo_d   = neg_lo_q;
        neg_hi_d   = neg_hi_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (i_start && !i_kill) begin
                    if (i_op[2]) begin
                        // MTHI/MTLO; 11x falls through untouched
                        if (!i_op[1]) begin
                            if (i_op[0]) lo_d = i_data_a;
                            else         hi_d = i_data_a;
                        end
                    end else if (i_op[1] && (i_data_b == '0)) begin
                        div_zero_d = 1'b1;
                    end else begin
                        state_d  = S_RUN;
                        cnt_d    = CW'(ITER - 1);
                        is_div_d = i_op[1];
                        hi_acc_d = '0;
                        neg_lo_d = sa ^ sb;
                        if (i_op[1]) begin
                            lo_acc_d = mag_a;
                            opnd_d   = mag_b;
                            neg_hi_d = sa;
                        end else begin
                            lo_acc_d = mag_b;
                            opnd_d   = mag_a;
                            neg_hi_d = 1'b0;
                        end
                    end
                end
            end
            S_RUN: begin
                if (i_kill) begin
                    state_d = S_IDLE;
                end else begin
                    hi_acc_d = hi_n;
                    lo_acc_d = lo_n;
                    if (cnt_q == '0) state_d = S_FIX;
                    else             cnt_d   = cnt_q - 1'b1;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!i_kill) begin
                    hi_d   = fix_hi;
                    lo_d   = fix_lo;
                    done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            hi_acc_q   <= '0;
            lo_acc_q   <= '0;
            opnd_q     <= '0;
            is_div_q   <= 1'b0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_acc_q   <= hi_acc_d;
            lo_acc_q   <= lo_acc_d;
            opnd_q     <= opnd_d;
            is_div_q   <= is_div_d;
            neg_lo_q   <= neg_lo_d;
            neg_hi_q   <= neg_hi_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign o_busy     = (state_q != S_IDLE);
    assign o_done     = done_q;
    assign o_hi       = hi_q;
    assign o_lo       = lo_q;
    assign o_div_zero = div_zero_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter (W=32, STEP=1).
// Stimulus at negedge, sampling at negedge; cycle n = n edges after start.
module tb_mdu_iter;

    localparam int W = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_NOP   = 3'b110;

    logic         i_clk = 1'b0;
    logic         i_arst;
    logic         i_start;
    logic [2:0]   i_op;
    logic [W-1:0] i_data_a;
    logic [W-1:0] i_data_b;
    logic         i_kill;
    logic         o_busy;
    logic         o_done;
    logic [W-1:0] o_hi;
    logic [W-1:0] o_lo;
    logic         o_div_zero;

    int n_cmp = 0;
    int n_bad = 0;

    mdu_iter #(.DATA_WIDTH(W), .STEP(1)) dut (
        .i_clk      (i_clk),
        .i_arst     (i_arst),
        .i_start    (i_start),
        .i_op       (i_op),
        .i_data_a   (i_data_a),
        .i_data_b   (i_data_b),
        .i_kill     (i_kill),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_hi       (o_hi),
        .o_lo       (o_lo),
        .o_div_zero (o_div_zero)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Single-edge request; returns at the cycle-1 negedge.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        i_start  = 1'b1;
        i_op     = op;
        i_data_a = a;
        i_data_b = b;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        @(negedge i_clk);
    endtask

    // Iterative request; returns at the negedge of the done cycle.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, output int done_cyc,
                          output int busy_bad);
        done_cyc = -1;
        busy_bad = 0;
        i_start  = 1'b1;
        i_op     = op;
        i_data_a = a;
        i_data_b = b;
        @(posedge i_clk);
        #1;
        i_start  = 1'b0;
        // Operands are latched: scramble them
        i_op     = OP_NOP;
        i_data_a = 32'hA5A5_5A5A;
        i_data_b = 32'h0000_0000;
        for (int c = 1; c <= 40; c++) begin
            @(negedge i_clk);
            if (o_done) begin
                done_cyc = c;
                if (o_busy) busy_bad++;
                break;
            end
            if (!o_busy) busy_bad++;
        end
    endtask

    task automatic count_done(input int n, output int seen);
        seen = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge i_clk);
            if (o_done) seen++;
        end
    endtask

    int          dc, bb, seen;
    logic [63:0] hl;

    initial begin
        i_arst   = 1'b1;
        i_start  = 1'b0;
        i_op     = OP_NOP;
        i_data_a = '0;
        i_data_b = '0;
        i_kill   = 1'b0;
        #1;
        chk("rst_hilo", {o_hi, o_lo}, 64'h0);
        chk("rst_flags", {61'h0, o_busy, o_done, o_div_zero}, 64'h0);
        repeat (2) @(negedge i_clk);
        i_arst = 1'b0;

        // First start right on the first edge after reset release
        run_op(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002, dc, bb);
        chk("mult_lat", 64'(dc), 64'd34);
        chk("mult_busy", 64'(bb), 64'd0);
        chk("mult_res", {o_hi, o_lo}, 64'hFFFF_FFFF_FFFF_FFFE);

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, dc, bb);
        chk("multu_lat", 64'(dc), 64'd34);
        chk("multu_res", {o_hi, o_lo}, 64'h0000_0001_FFFF_FFFE);

        // Back-to-back start in the done cycle
        run_op(OP_MULTU, 32'h1234_5678, 32'h0000_0010, dc, bb);
        chk("b2b_lat", 64'(dc), 64'd34);
        chk("b2b_busy", 64'(bb), 64'd0);
        chk("b2b_res", {o_hi, o_lo}, 64'h0000_0001_2345_6780);

        run_op(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, dc, bb);
        chk("div_neg_lat", 64'(dc), 64'd34);
        chk("div_neg_res", {o_hi, o_lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, dc, bb);
        chk("div_ovf_res", {o_hi, o_lo}, 64'h0000_0000_8000_0000);

        run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, dc, bb);
        chk("mult_min_res", {o_hi, o_lo}, 64'h4000_0000_0000_0000);

        run_op(OP_DIVU, 32'd100, 32'd7, dc, bb);
        chk("divu_res", {o_hi, o_lo}, 64'h0000_0002_0000_000E);

        run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, dc, bb);
        chk("div_pn_res", {o_hi, o_lo}, 64'h0000_0001_FFFF_FFFD);

        issue(OP_MTHI, 32'h0000_1111, 32'h0);
        chk("mthi_busy", {63'h0, o_busy}, 64'h0);
        issue(OP_MTLO, 32'h0000_2222, 32'h0);
        chk("mtlo_res", {o_hi, o_lo}, 64'h0000_1111_0000_2222);

        // Divide by zero
        issue(OP_DIVU, 32'd5, 32'd0);
        chk("dz_flags", {61'h0, o_busy, o_done, o_div_zero}, 64'h1);
        chk("dz_hilo", {o_hi, o_lo}, 64'h0000_1111_0000_2222);
        @(negedge i_clk);
        chk("dz_pulse", {63'h0, o_div_zero}, 64'h0);
        count_done(40, seen);
        chk("dz_nodone", 64'(seen), 64'd0);

        issue(OP_NOP, 32'h77, 32'h88);
        chk("nop_hilo", {o_hi, o_lo}, 64'h0000_1111_0000_2222);

        // Kill beats start in IDLE
        i_kill = 1'b1;
        issue(OP_MTHI, 32'h5555_5555, 32'h0);
        i_kill = 1'b0;
        chk("kill_idle", {o_hi, o_lo}, 64'h0000_1111_0000_2222);

        // Kill in RUN, with an ignored start while busy
        hl       = {o_hi, o_lo};
        i_start  = 1'b1;
        i_op     = OP_MULT;
        i_data_a = 32'd3;
        i_data_b = 32'd4;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge i_clk);
            if (c == 5) begin
                i_start  = 1'b1;
                i_op     = OP_MTHI;
                i_data_a = 32'hDEAD_BEEF;
            end
            if (c == 6) begin
                i_start = 1'b0;
                chk("busy_ign", {o_busy, o_hi}, {1'b1, hl[63:32]});
            end
        end
        i_kill = 1'b1;
        @(negedge i_clk);
        i_kill = 1'b0;
        chk("kill_busy", {63'h0, o_busy}, 64'h0);
        count_done(40, seen);
        chk("kill_nodone", 64'(seen), 64'd0);
        chk("kill_hilo", {o_hi, o_lo}, hl);

        // Asynchronous reset mid-divide
        i_start  = 1'b1;
        i_op     = OP_DIVU;
        i_data_a = 32'd1000;
        i_data_b = 32'd3;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        for (int c = 1; c <= 20; c++) @(negedge i_clk);
        i_arst = 1'b1;
        #1;
        chk("arst_hilo", {o_hi, o_lo}, 64'h0);
        chk("arst_flags", {61'h0, o_busy, o_done, o_div_zero}, 64'h0);
        @(negedge i_clk);
        i_arst = 1'b0;
        issue(OP_MTHI, 32'hABCD_0000, 32'h0);
        chk("arst_mthi", {o_hi, o_lo}, 64'hABCD_0000_0000_0000);
        chk("arst_mthi_busy", {63'h0, o_busy}, 64'h0);
        count_done(40, seen);
        chk("arst_nodone", 64'(seen), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, which is the operand width W.
REQ-002 The block SHALL have parameter STEP, default 1, which is the number of iteration bits processed per cycle; legal values are 1, 2 and 4, and W mod STEP = 0.
REQ-003 The block SHALL have parameter ITER = DATA_WIDTH/STEP, derived and not overridable.
REQ-004 The block SHALL have port i_clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port i_arst, input, 1 bit: asynchronous active-high reset.
REQ-006 The block SHALL have port i_start, input, 1 bit: operation request, sampled on the rising edge.
REQ-007 The block SHALL have port i_op, input, 3 bits: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op.
REQ-008 The block SHALL have ports i_data_a and i_data_b, inputs, W bits each: operands (a = multiplicand/dividend, b = multiplier/divisor).
REQ-009 The block SHALL have port i_kill, input, 1 bit: pipeline flush (exception or interrupt).
REQ-010 The block SHALL have port o_busy, output, 1 bit: operation in flight; the pipeline stalls on HI/LO readers while it is high.
REQ-011 The block SHALL have port o_done, output, 1 bit: one-cycle pulse signalling that new o_hi/o_lo are valid.
REQ-012 The block SHALL have ports o_hi and o_lo, outputs, W bits each: the architectural HI/LO registers.
REQ-013 The block SHALL have port o_div_zero, output, 1 bit: one-cycle pulse on a DIV/DIVU request with b = 0.

Function
REQ-014 The block SHALL implement a state machine with states IDLE, RUN and FIX, and o_busy SHALL equal (state != IDLE).
REQ-015 A start SHALL be accepted only in IDLE when i_start=1 and i_kill=0; i_start in RUN or FIX SHALL be ignored.
REQ-016 An accepted MTHI SHALL load o_hi <= i_data_a at that edge and MTLO SHALL load o_lo <= i_data_a; the state SHALL remain IDLE, with no o_done and no o_busy.
REQ-017 An accepted 11x op SHALL leave all state and outputs unchanged.
REQ-018 An accepted MULT/MULTU/DIV/DIVU with nonzero divisor SHALL latch the operand magnitudes and result sign(s) and go IDLE->RUN.
REQ-019 RUN SHALL last exactly ITER cycles, each performing STEP shift-add steps (multiply) or STEP restoring shift-subtract steps (divide); it then goes RUN->FIX.
REQ-020 FIX SHALL last one cycle, apply two's-complement sign correction for the signed ops, and then go FIX->IDLE.
REQ-021 On the FIX->IDLE edge, o_hi/o_lo SHALL be loaded and o_done SHALL be set for exactly one cycle.
REQ-022 With the start edge at cycle 0, new results and o_done SHALL be visible in cycle ITER+2, and o_busy SHALL be high in cycles 1..ITER+1.
REQ-023 In the o_done cycle o_busy SHALL be 0, so a new start SHALL be accepted in that same cycle (back-to-back operation).
REQ-024 Multiply results SHALL be full 2W-bit products, {o_hi,o_lo}; MULT is signed x signed and MULTU is unsigned x unsigned.
REQ-025 Divide results SHALL be o_lo = quotient and o_hi = remainder.
REQ-026 DIV SHALL truncate the quotient toward zero and give the remainder the sign of the dividend.
REQ-027 For DIV of the most-negative value by -1, o_lo SHALL equal the most-negative value and o_hi SHALL equal 0, with no flag.
REQ-028 DIV/DIVU with b=0 SHALL assert o_div_zero in the cycle after the start edge, leave o_hi/o_lo unchanged, keep the state IDLE and not assert o_done.
REQ-029 i_kill=1 in RUN or FIX SHALL force the state to IDLE at the next edge, with o_hi/o_lo unchanged and no o_done.
REQ-030 If i_kill and i_start are both 1 in IDLE, the kill SHALL win and the start SHALL be discarded.
REQ-031 i_data_a, i_data_b and i_op SHALL be ignored after the start edge, because the operands are latched.

Reset
REQ-032 While i_arst=1, asynchronously: state SHALL be IDLE, o_hi = 0, o_lo = 0, o_busy = 0, o_done = 0, o_div_zero = 0, and all internal iteration registers SHALL be 0.
REQ-033 An assertion of i_arst mid-operation SHALL abort the operation with no o_done after release.
REQ-034 The first start SHALL be accepted on the first rising edge at which i_arst is deasserted.

Verification (W=32, STEP=1, ITER=32)
REQ-035 The bench SHALL cover MULT a=0xFFFFFFFF, b=0x00000002 at cycle 0 -> o_done in cycle 34, o_hi=0xFFFFFFFF, o_lo=0xFFFFFFFE, o_busy high in cycles 1-33.
REQ-036 The bench SHALL cover MULTU with the same operands -> o_hi=0x00000001, o_lo=0xFFFFFFFE, and a second MULTU started in the o_done cycle completing 34 cycles later.
REQ-037 The bench SHALL cover DIV a=0xFFFFFFF9 (-7), b=2 -> o_lo=0xFFFFFFFD, o_hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> o_lo=0x80000000, o_hi=0.
REQ-038 The bench SHALL cover DIVU a=5, b=0 with prior o_hi/o_lo = 0x1111/0x2222 -> o_div_zero pulse in cycle 1, o_hi/o_lo unchanged, o_busy=0, no o_done.
REQ-039 The bench SHALL cover MULT started, i_kill=1 in cycle 10 -> o_busy=0 from cycle 11, no o_done, o_hi/o_lo unchanged; start ignored while busy.
REQ-040 The bench SHALL cover i_arst pulsed in cycle 20 of a DIVU -> all outputs 0 immediately; then MTHI 0xABCD0000 -> o_hi=0xABCD0000 next cycle, o_busy stays 0.
